oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock, with reset synchronous and active-high:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_ce  in  1  CPU cycle enable; one CPU bus cycle per clk with cpu_ce=1
- cpu_addr  in  16  CPU bus address
- cpu_din  in  8  CPU write data
- cpu_WE  in  1  CPU write strobe
- bus_rdata  in  8  read data returned by the memory mapper for dma_addr
- cpu_stall  out  1  halts the CPU (RDY low)
- dma_active  out  1  DMA owns the CPU bus; mapper address/WE/wdata muxed from dma_*
- dma_addr  out  16  DMA bus address
- dma_wdata  out  8  DMA write data
- dma_WE  out  1  DMA write strobe
- dma_done  out  1  one-cycle completion pulse
REQ-002 The block SHALL have no parameters.

Function
REQ-003 All registered state (FSM, counter, page, data latch, parity) SHALL update only on clk edges where cpu_ce=1, except reset and dma_done clearing.
REQ-004 Parity flop SHALL toggle every cpu_ce cycle; 0 = even; the first cpu_ce cycle after reset is even.
REQ-005 FSM states SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-006 Trigger: in IDLE, cpu_ce & cpu_WE & cpu_addr==16'h4014 SHALL latch page=cpu_din, clear cnt (8 bits) to 0, and go to HALT.
REQ-007 Writes to any other address (including 16'h4013, 16'h4015) SHALL NOT trigger; writes to 16'h4014 outside IDLE SHALL be ignored.
REQ-008 HALT lasts one CPU cycle; next state SHALL be ALIGN if the following cycle is odd, else READ.
REQ-009 ALIGN lasts one CPU cycle, then READ; READ SHALL therefore always occur on even cycles.
REQ-010 READ: dma_addr={page,cnt}, dma_WE=0; bus_rdata SHALL be captured into the data latch at the end of the cycle; next state WRITE.
REQ-011 WRITE: dma_addr=16'h2004, dma_wdata=latch, dma_WE=1; cnt increments mod 256; next state SHALL be READ if cnt!=255, else IDLE.
REQ-012 Page SHALL be used unmodified (pages 0x20-0x3F read through the mapper as normal bus reads; no special case).
REQ-013 cpu_stall SHALL be 1 in HALT, ALIGN, READ, WRITE; dma_active SHALL be 1 only in READ and WRITE.
REQ-014 Outside READ/WRITE: dma_addr=0, dma_wdata=0, dma_WE=0.
REQ-015 Stall length SHALL be 513 CPU cycles for a trigger on an even cycle and 514 for a trigger on an odd cycle.
REQ-016 dma_done SHALL be registered, high for exactly one clk after the edge leaving the final WRITE, and cleared on the next clk regardless of cpu_ce.
REQ-017 cpu_stall, dma_active and dma_WE SHALL be decoded combinationally from state; there SHALL be no extra latency.
REQ-018 While cpu_ce=0, all outputs SHALL hold their values.

Reset
REQ-019 On reset=1 at a clk edge: state=IDLE, cnt=0, page=0, latch=0, parity=0, dma_done=0; thus cpu_stall=dma_active=dma_WE=0 and dma_addr=dma_wdata=0, with no cpu_ce qualification.
REQ-020 Reset mid-transfer SHALL abort: no further dma_WE, and a subsequent trigger starts a fresh 256-byte transfer.

Verification
REQ-021 Reset with cpu_ce=1 for 3 cycles -> all outputs 0; no dma_WE for 100 further cycles without a trigger.
REQ-022 Write 0x02 to 16'h4014 on an even cycle, memory[0x0200+i]=i^0x5A -> cpu_stall high 513 cycles; 256 writes to 16'h2004 carrying 0x5A,0x5B,... in order; dma_done pulses once after the last write.
REQ-023 Same transfer triggered on an odd cycle -> one ALIGN cycle; stall 514 cycles; first READ addr 16'h0200 on an even cycle.
REQ-024 Writes of 0x02 to 16'h4013 and 16'h4015 -> cpu_stall stays 0, no dma_WE.
REQ-025 Reset asserted in the WRITE of pair 100 -> cpu_stall 0 from the next cycle; exactly 100 dma_WE pulses observed; a new trigger with page 0x03 reads 16'h0300 first.
REQ-026 cpu_ce held low 10 clks during READ of pair 50 -> outputs frozen, dma_addr stays {page,8'd50}; transfer completes with 256 writes and a 513-cycle stall counted in cpu_ce cycles.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: 256-byte sprite DMA that halts the CPU and copies {page,00..FF} to 16'h2004 in read/write pairs
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_WE,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_stall,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_WE,
  output logic        dma_done
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, page, latch;
  logic parity;
  logic trig;
  assign trig = state == IDLE && cpu_WE && cpu_addr == 16'h4014;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = trig ? HALT : IDLE;
      HALT:    state_nxt = parity ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = cnt == 8'hFF ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end
  assign cpu_stall  = state != IDLE;
  assign dma_active = state == READ || state == WRITE;
  assign dma_WE     = state == WRITE;
  assign dma_addr   = state == READ ? {page, cnt} : state == WRITE ? 16'h2004 : 16'h0000;
  assign dma_wdata  = state == WRITE ? latch : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'h00;
      page     <= 8'h00;
      latch    <= 8'h00;
      parity   <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= cpu_ce && state == WRITE && cnt == 8'hFF;
      if (cpu_ce) begin
        state  <= state_nxt;
        parity <= ~parity;
        if (trig) begin
          page <= cpu_din;
          cnt  <= 8'h00;
        end
        if (state == READ) latch <= bus_rdata;
        if (state == WRITE) cnt <= cnt + 8'h01;
      end
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_ce = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_WE = 1'b0;
  logic [7:0]  bus_rdata;
  logic        cpu_stall, dma_active, dma_WE, dma_done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  int errs = 0, checks = 0;
  int stall_cnt = 0, halt_cnt = 0, we_cnt = 0, done_cnt = 0, bad = 0, frz_bad = 0;
  logic        par_tb = 1'b0, rd_seen = 1'b0, rd_par = 1'b0, p;
  logic [15:0] rd_addr = 16'h0000;
  logic [7:0]  pg = 8'h00;
  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_WE(cpu_WE), .bus_rdata(bus_rdata), .cpu_stall(cpu_stall), .dma_active(dma_active),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_WE(dma_WE), .dma_done(dma_done)
  );
  // memory image: page 2 holds i^5A, page 3 holds i^5A^01
  assign bus_rdata = dma_addr[7:0] ^ 8'h5A ^ (dma_addr[15:8] - 8'h02);
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (dma_done) done_cnt++;
    if (cpu_ce) begin
      if (cpu_stall) stall_cnt++;
      if (cpu_stall && !dma_active) halt_cnt++;
      if (dma_WE) begin
        if (dma_addr !== 16'h2004 || dma_wdata !== (we_cnt[7:0] ^ 8'h5A ^ (pg - 8'h02))) bad++;
        we_cnt++;
      end
      if (dma_active && !dma_WE && !rd_seen) begin
        rd_seen = 1'b1;
        rd_addr = dma_addr;
        rd_par  = par_tb;
      end
    end
    par_tb = reset ? 1'b0 : par_tb ^ cpu_ce;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic trigger(input logic [15:0] a, input logic [7:0] d, input logic odd);
    while (par_tb != odd) cyc();
    stall_cnt = 0; halt_cnt = 0; we_cnt = 0; done_cnt = 0; bad = 0; rd_seen = 1'b0; pg = d;
    cpu_WE = 1'b1; cpu_addr = a; cpu_din = d;
    cyc();
    cpu_WE = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
  endtask
  task automatic wait_done();
    for (int k = 0; k < 3000 && !dma_done; k++) cyc();
    chk("done_seen", dma_done, 1);
    repeat (3) cyc();
  endtask
  initial begin
    repeat (3) cyc();
    chk("rst_stall", cpu_stall, 0);
    chk("rst_active", dma_active, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_wdata", dma_wdata, 0);
    chk("rst_we", dma_WE, 0);
    chk("rst_done", dma_done, 0);
    reset = 1'b0;
    repeat (100) cyc();
    chk("idle_we", we_cnt, 0);
    trigger(16'h4014, 8'h02, 1'b0);
    chk("trig_stall", cpu_stall, 1);
    wait_done();
    chk("even_stall", stall_cnt, 513);
    chk("even_halt", halt_cnt, 1);
    chk("even_writes", we_cnt, 256);
    chk("even_data", bad, 0);
    chk("even_done", done_cnt, 1);
    chk("even_rd_addr", rd_addr, 16'h0200);
    chk("even_rd_par", rd_par, 0);
    chk("even_end_stall", cpu_stall, 0);
    trigger(16'h4014, 8'h02, 1'b1);
    wait_done();
    chk("odd_stall", stall_cnt, 514);
    chk("odd_halt", halt_cnt, 2);
    chk("odd_writes", we_cnt, 256);
    chk("odd_data", bad, 0);
    chk("odd_done", done_cnt, 1);
    chk("odd_rd_addr", rd_addr, 16'h0200);
    chk("odd_rd_par", rd_par, 0);
    stall_cnt = 0; we_cnt = 0;
    cpu_WE = 1'b1; cpu_addr = 16'h4013; cpu_din = 8'h02; cyc();
    cpu_addr = 16'h4015; cyc();
    cpu_WE = 1'b0; cpu_addr = 16'h0000;
    repeat (5) cyc();
    chk("near_stall", stall_cnt, 0);
    chk("near_we", we_cnt, 0);
    trigger(16'h4014, 8'h02, 1'b0);
    for (int k = 0; k < 1000 && !(dma_WE && we_cnt == 99); k++) cyc();
    chk("abort_at_w100", dma_WE && we_cnt == 99, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_stall", cpu_stall, 0);
    chk("abort_active", dma_active, 0);
    repeat (20) cyc();
    chk("abort_writes", we_cnt, 100);
    chk("abort_data", bad, 0);
    p = par_tb;
    trigger(16'h4014, 8'h03, p);
    wait_done();
    chk("p3_rd_addr", rd_addr, 16'h0300);
    chk("p3_writes", we_cnt, 256);
    chk("p3_data", bad, 0);
    chk("p3_stall", stall_cnt, p ? 514 : 513);
    trigger(16'h4014, 8'h02, 1'b0);
    for (int k = 0; k < 1000 && !(dma_active && !dma_WE && dma_addr == 16'h0232); k++) cyc();
    chk("frz_reach", dma_addr, 16'h0232);
    cpu_ce = 1'b0;
    repeat (10) begin
      cyc();
      if (dma_addr !== 16'h0232 || !cpu_stall || !dma_active || dma_WE) frz_bad++;
    end
    chk("frz_hold", frz_bad, 0);
    cpu_ce = 1'b1;
    wait_done();
    chk("frz_stall", stall_cnt, 513);
    chk("frz_writes", we_cnt, 256);
    chk("frz_data", bad, 0);
    chk("frz_done", done_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
